// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared types, widths and arithmetic helpers for the binary-weight layers
// Contents:
//   state_e      frame sequencer states (IDLE, ACC, DONE)
//   DEF_*        default layer dimensions and the accumulator width derived from them
//   FN_W         working width of the helper functions (accumulators must fit in it)
//   sat_signed   clamp a signed value to the range of an out_bits-wide signed number
//   sext_neg     conditionally negate an already sign-extended value
package bnn_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEF_OUT_CNT = 8;
   localparam int DEF_IN_CNT  = 16;
   localparam int DEF_IN_BIT  = 8;
   localparam int DEF_ACC_BIT = DEF_IN_BIT + $clog2(DEF_OUT_CNT) + 1;

   localparam int FN_W = 32;

   function automatic logic signed [FN_W-1:0] sat_signed(input logic signed [FN_W-1:0] acc,
                                                         input int out_bits);
      logic signed [FN_W-1:0] hi;
      logic signed [FN_W-1:0] lo;
      hi = $signed((32'd1 << (out_bits - 1)) - 32'd1);
      lo = -hi - 32'sd1;
      if (acc > hi)      return hi;
      else if (acc < lo) return lo;
      else               return acc;
   endfunction

   // Callers widen before negating so that negating the most negative input is exact.
   function automatic logic signed [FN_W-1:0] sext_neg(input logic signed [FN_W-1:0] value,
                                                       input logic neg);
      return neg ? -value : value;
   endfunction

endpackage

// File: rtl/bin_grad_acc_lane.sv
// rtl/bin_grad_acc_lane.sv - one input-gradient accumulator lane with saturating output
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears the accumulator)
//   load         start of frame: acc = +/-g, discarding any previous value
//   en           mid-frame beat: acc += +/-g
//   neg          weight bit was 0 (-1), so the beat is subtracted
//   g            signed gradient beat
//   res          acc saturated to IN_BIT signed
module bin_grad_acc_lane
   import bnn_pkg::*;
#(
   parameter int IN_BIT  = 8,
   parameter int ACC_BIT = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load,
   input  logic                     en,
   input  logic                     neg,
   input  logic signed [IN_BIT-1:0] g,
   output logic signed [IN_BIT-1:0] res
);

   logic signed [ACC_BIT-1:0] acc_q;
   logic signed [ACC_BIT-1:0] acc_d;
   logic signed [FN_W-1:0]    term;
   logic signed [FN_W-1:0]    sat_val;

   always_comb begin
      term    = sext_neg(FN_W'(g), neg);
      sat_val = sat_signed(FN_W'(acc_q), IN_BIT);
      acc_d   = acc_q;
      if (load)    acc_d = ACC_BIT'(term);
      else if (en) acc_d = acc_q + ACC_BIT'(term);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_d;
   end

   assign res = IN_BIT'(sat_val);

endmodule

// File: rtl/bin_weight_transpose_grad_seq.sv
// rtl/bin_weight_transpose_grad_seq.sv - serial transpose product of binary weights and output gradients
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   weight[OUT][IN]                   binary weights (1 = +1, 0 = -1), stable for a frame
//   g_valid/g_ready/g_data/g_last     gradient beat stream, one row per beat
//   res_valid/res_ready               result handshake
//   res_data[IN]                      saturated grad_in[j] = sum_i (w[i][j] ? g[i] : -g[i])
//   res_len_err                       with res_valid: frame length differed from OUT_CNT
module bin_weight_transpose_grad_seq
   import bnn_pkg::*;
#(
   parameter int PARAM_OUT_CNT = 8,
   parameter int PARAM_IN_CNT  = 16,
   parameter int PARAM_IN_BIT  = 8,
   parameter int PARAM_ACC_BIT = PARAM_IN_BIT + $clog2(PARAM_OUT_CNT) + 1
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic [PARAM_OUT_CNT-1:0][PARAM_IN_CNT-1:0]   weight,
   input  logic                                         g_valid,
   output logic                                         g_ready,
   input  logic signed [PARAM_IN_BIT-1:0]               g_data,
   input  logic                                         g_last,
   output logic                                         res_valid,
   input  logic                                         res_ready,
   output logic [PARAM_IN_CNT-1:0][PARAM_IN_BIT-1:0]    res_data,
   output logic                                         res_len_err
);

   localparam int ROW_W = (PARAM_OUT_CNT > 1) ? $clog2(PARAM_OUT_CNT) : 1;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(PARAM_OUT_CNT - 1);

   state_e            state_q;
   logic [ROW_W-1:0]  row_q;
   logic              g_ready_q;
   logic              res_valid_q;
   logic              len_err_q;

   logic                           accept;
   logic                           at_last_row;
   logic                           frame_end;
   logic                           load;
   logic                           en;
   logic [PARAM_IN_CNT-1:0]        w_row;
   logic signed [PARAM_IN_BIT-1:0] lane_res [PARAM_IN_CNT];

   assign accept      = g_valid && g_ready_q;
   assign at_last_row = (row_q == LAST_ROW);
   // An explicit last or running out of rows both close the frame.
   assign frame_end   = g_last || at_last_row;
   assign load        = accept && (state_q == IDLE);
   assign en          = accept && (state_q == ACC);
   assign w_row       = weight[row_q];

   // g_ready is registered so it stays low while reset is held and the cycle after.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         row_q       <= '0;
         g_ready_q   <= 1'b0;
         res_valid_q <= 1'b0;
         len_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, ACC: begin
               g_ready_q <= 1'b1;
               if (accept) begin
                  if (frame_end) begin
                     state_q     <= DONE;
                     g_ready_q   <= 1'b0;
                     res_valid_q <= 1'b1;
                     // Error when last came early or was missing on the final row.
                     len_err_q   <= g_last ^ at_last_row;
                  end else begin
                     state_q <= ACC;
                     row_q   <= row_q + 1'b1;
                  end
               end
            end
            DONE: begin
               if (res_ready) begin
                  state_q     <= IDLE;
                  row_q       <= '0;
                  g_ready_q   <= 1'b1;
                  res_valid_q <= 1'b0;
                  len_err_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               row_q   <= '0;
            end
         endcase
      end
   end

   for (genvar j = 0; j < PARAM_IN_CNT; j++) begin : g_lane
      bin_grad_acc_lane #(
         .IN_BIT  (PARAM_IN_BIT),
         .ACC_BIT (PARAM_ACC_BIT)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (load),
         .en    (en),
         .neg   (!w_row[j]),
         .g     (g_data),
         .res   (lane_res[j])
      );
      assign res_data[j] = lane_res[j];
   end

   assign g_ready     = g_ready_q;
   assign res_valid   = res_valid_q;
   assign res_len_err = len_err_q;

   // Weights feed the row mux every beat, so they must not move inside a frame.
   weight_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
                                     (state_q == ACC) |-> $stable(weight));

endmodule
